// File: rtl/alarm_clock_pkg.sv
// Shared definitions for the alarm clock: time field width, field limits and
// the time-keeper state encoding that also serves as the edit_field decode.
package alarm_clock_pkg;

    localparam int unsigned TIME_W = 6;

    localparam logic [TIME_W-1:0] HOURS_MAX = 6'd23;
    localparam logic [TIME_W-1:0] MINS_MAX  = 6'd59;
    localparam logic [TIME_W-1:0] SECS_MAX  = 6'd59;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10
    } state_t;

    function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] value,
                                                   input logic [TIME_W-1:0] max);
        return (value == max) ? '0 : value + TIME_W'(1);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector; a held button
// produces exactly one single-cycle pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic pulse
);

    logic sync_q1;
    logic sync_q2;
    logic prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
        end
    end

    assign pulse = sync_q2 & ~prev_q;

endmodule

// File: rtl/time_keeper.sv
// 24-hour time-of-day counter with a 1 Hz prescaler and a push-button set mode
// for editing the hour and minute fields.
module time_keeper
    import alarm_clock_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 100000000,
    parameter int unsigned RESET_HOUR = 0,
    parameter int unsigned RESET_MIN  = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              set_en,
    input  logic              btn_sel,
    input  logic              btn_inc,
    output logic [TIME_W-1:0] hour_out,
    output logic [TIME_W-1:0] min_out,
    output logic [TIME_W-1:0] sec_out,
    output logic              sec_tick,
    output logic [1:0]        edit_field
);

    localparam int unsigned PW = $clog2(CLK_DIV);

    logic          set_q1;
    logic          set_s;
    logic          sel_p;
    logic          inc_p;
    logic [PW-1:0] presc;
    state_t        state;
    state_t        state_next;
    logic          tick_due;
    logic          run_stay;
    logic [1:0]    edit_next;

    btn_sync_edge u_sel (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_sel),
        .pulse   (sel_p)
    );

    btn_sync_edge u_inc (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_inc),
        .pulse   (inc_p)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            set_q1 <= 1'b0;
            set_s  <= 1'b0;
        end else begin
            set_q1 <= set_en;
            set_s  <= set_q1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_RUN: begin
                if (set_s) state_next = ST_SET_HOUR;
            end
            ST_SET_HOUR: begin
                if (!set_s)     state_next = ST_RUN;
                else if (sel_p) state_next = ST_SET_MIN;
            end
            ST_SET_MIN: begin
                if (!set_s)     state_next = ST_RUN;
                else if (sel_p) state_next = ST_SET_HOUR;
            end
            default: state_next = ST_RUN;
        endcase
    end

    // A tick only fires when RUN persists, so entering set mode suppresses it.
    always_comb begin
        run_stay = (state == ST_RUN) && (state_next == ST_RUN);
        tick_due = run_stay && (presc == PW'(CLK_DIV - 1));
        edit_next = 2'b00;
        unique case (state_next)
            ST_SET_HOUR: edit_next = 2'b01;
            ST_SET_MIN:  edit_next = 2'b10;
            default:     edit_next = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc      <= '0;
            sec_tick   <= 1'b0;
            edit_field <= 2'b00;
            hour_out   <= TIME_W'(RESET_HOUR);
            min_out    <= TIME_W'(RESET_MIN);
            sec_out    <= '0;
        end else begin
            sec_tick   <= tick_due;
            edit_field <= edit_next;

            if (!run_stay || tick_due) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end

            if (state == ST_RUN && state_next == ST_SET_HOUR) begin
                sec_out <= '0;
            end else if (tick_due) begin
                sec_out <= wrap_inc(sec_out, SECS_MAX);
                if (sec_out == SECS_MAX) begin
                    min_out <= wrap_inc(min_out, MINS_MAX);
                    if (min_out == MINS_MAX) begin
                        hour_out <= wrap_inc(hour_out, HOURS_MAX);
                    end
                end
            end else if (inc_p) begin
                // Increment targets the field of the current state, before any sel toggle.
                if (state == ST_SET_HOUR) begin
                    hour_out <= wrap_inc(hour_out, HOURS_MAX);
                end else if (state == ST_SET_MIN) begin
                    min_out <= wrap_inc(min_out, MINS_MAX);
                end
            end
        end
    end

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: a table of set-mode edits plus hand-written
// sequences for tick timing, rollover, button latency, collisions and reset.
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       set_en = 1'b0;
    logic       btn_sel = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] hour_out;
    logic [5:0] min_out;
    logic [5:0] sec_out;
    logic       sec_tick;
    logic [1:0] edit_field;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    time_keeper #(
        .CLK_DIV    (4),
        .RESET_HOUR (7),
        .RESET_MIN  (30)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .set_en     (set_en),
        .btn_sel    (btn_sel),
        .btn_inc    (btn_inc),
        .hour_out   (hour_out),
        .min_out    (min_out),
        .sec_out    (sec_out),
        .sec_tick   (sec_tick),
        .edit_field (edit_field)
    );

    typedef struct {
        int n_sel;
        int n_inc;
        int hour;
        int min;
        int sec;
        int edit;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input bit sel);
        if (sel) btn_sel = 1'b1; else btn_inc = 1'b1;
        step(4);
        btn_sel = 1'b0;
        btn_inc = 1'b0;
        step(4);
    endtask

    initial begin
        int first_tick;
        int tick_cnt;

        vecs[0]  = '{0,  0,  7, 30, 0, 1};
        vecs[1]  = '{0,  1,  8, 30, 0, 1};
        vecs[2]  = '{0, 24,  8, 30, 0, 1};
        vecs[3]  = '{0, 15, 23, 30, 0, 1};
        vecs[4]  = '{1,  0, 23, 30, 0, 2};
        vecs[5]  = '{0, 61, 23, 31, 0, 2};
        vecs[6]  = '{0, 28, 23, 59, 0, 2};
        vecs[7]  = '{0,  1, 23,  0, 0, 2};
        vecs[8]  = '{0, 59, 23, 59, 0, 2};
        vecs[9]  = '{1,  0, 23, 59, 0, 1};
        vecs[10] = '{1,  0, 23, 59, 0, 2};

        // Reset state, checked before the first clock edge.
        #1 reset_n = 1'b0;
        #2;
        check("rst_hour", hour_out, 7);
        check("rst_min", min_out, 30);
        check("rst_sec", sec_out, 0);
        check("rst_tick", sec_tick, 0);
        check("rst_edit", edit_field, 0);

        @(posedge clk);
        #7 reset_n = 1'b1;

        // Tick every 4 cycles; the first lands on the 4th edge after release.
        for (int i = 0; i < 16; i++) begin
            step(1);
            check($sformatf("run_tick_%0d", i), sec_tick, (i % 4 == 3) ? 1 : 0);
            if (i == 3) check("first_sec", sec_out, 1);
        end
        check("run_sec4", sec_out, 4);
        check("run_hour", hour_out, 7);
        check("run_min", min_out, 30);

        set_en = 1'b1;
        step(4);
        foreach (vecs[k]) begin
            repeat (vecs[k].n_sel) press(1'b1);
            repeat (vecs[k].n_inc) press(1'b0);
            check($sformatf("vec%0d_hour", k), hour_out, vecs[k].hour);
            check($sformatf("vec%0d_min", k), min_out, vecs[k].min);
            check($sformatf("vec%0d_sec", k), sec_out, vecs[k].sec);
            check($sformatf("vec%0d_edit", k), edit_field, vecs[k].edit);
        end

        // Leave set mode at 23:59, run up to :58, then two rollover ticks.
        set_en = 1'b0;
        step(3);
        check("exit_edit", edit_field, 0);
        check("exit_tick", sec_tick, 0);
        first_tick = 0;
        tick_cnt = 0;
        for (int i = 1; i <= 232; i++) begin
            step(1);
            if (sec_tick) begin
                tick_cnt++;
                if (first_tick == 0) first_tick = i;
            end
        end
        check("exit_first_tick", first_tick, 4);
        check("exit_tick_cnt", tick_cnt, 58);
        check("t58_hour", hour_out, 23);
        check("t58_min", min_out, 59);
        check("t58_sec", sec_out, 58);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check($sformatf("t59_tick_%0d", i), sec_tick, (i == 3) ? 1 : 0);
        end
        check("t59_hour", hour_out, 23);
        check("t59_min", min_out, 59);
        check("t59_sec", sec_out, 59);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check($sformatf("t00_tick_%0d", i), sec_tick, (i == 3) ? 1 : 0);
        end
        check("t00_hour", hour_out, 0);
        check("t00_min", min_out, 0);
        check("t00_sec", sec_out, 0);

        // Held btn_inc in SET_MIN: one increment, 3 cycles after the edge.
        set_en = 1'b1;
        step(4);
        check("set_edit_hour", edit_field, 1);
        press(1'b1);
        check("set_edit_min", edit_field, 2);
        btn_inc = 1'b1;
        step(2);
        check("hold_min_c2", min_out, 0);
        step(1);
        check("hold_min_c3", min_out, 1);
        step(47);
        check("hold_min_c50", min_out, 1);
        btn_inc = 1'b0;
        step(4);
        check("hold_min_rel", min_out, 1);
        check("hold_hour", hour_out, 0);

        // set_en synced in the very cycle a tick is due: the transition wins.
        set_en = 1'b0;
        step(3);
        check("col_run_edit", edit_field, 0);
        step(8);
        check("col_sec2", sec_out, 2);
        step(1);
        set_en = 1'b1;
        step(2);
        check("col_pre_sec", sec_out, 2);
        check("col_pre_edit", edit_field, 0);
        check("col_pre_tick", sec_tick, 0);
        step(1);
        check("col_tick", sec_tick, 0);
        check("col_sec", sec_out, 0);
        check("col_edit", edit_field, 1);
        check("col_min", min_out, 1);
        step(1);
        check("col_tick_after", sec_tick, 0);

        // sel and inc together: hour increments, then the field toggles.
        btn_sel = 1'b1;
        btn_inc = 1'b1;
        step(4);
        btn_sel = 1'b0;
        btn_inc = 1'b0;
        step(4);
        check("both_hour", hour_out, 1);
        check("both_min", min_out, 1);
        check("both_edit", edit_field, 2);

        // Asynchronous reset between edges, with an inc edge still in the synchronizer.
        btn_inc = 1'b1;
        step(1);
        #3 reset_n = 1'b0;
        #1;
        check("arst_hour", hour_out, 7);
        check("arst_min", min_out, 30);
        check("arst_sec", sec_out, 0);
        check("arst_tick", sec_tick, 0);
        check("arst_edit", edit_field, 0);
        set_en = 1'b0;
        btn_inc = 1'b0;
        step(2);
        #3 reset_n = 1'b1;
        step(6);
        check("post_hour", hour_out, 7);
        check("post_min", min_out, 30);
        check("post_sec", sec_out, 1);
        check("post_edit", edit_field, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Time-of-day source for the alarm clock. Produces hour/minute/second values that the alarm comparator reads.
- Runs a 24-hour counter advanced by an internal 1 Hz prescaler.
- A user set mode lets the hour and minute fields be edited from push-buttons.
- Output widths and encodings match the comparator's time inputs, so the outputs connect directly.

Parameters:
- CLK_DIV, 100000000, number of clk cycles per second tick; must be >= 2.
- RESET_HOUR, 0, hour value loaded on reset (0..23).
- RESET_MIN, 0, minute value loaded on reset (0..59).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- set_en  input  1  level switch; high = set mode, low = run mode
- btn_sel  input  1  raw push-button level; rising edge toggles the edited field
- btn_inc  input  1  raw push-button level; rising edge increments the edited field
- hour_out  output  6  current hour, binary 0..23
- min_out  output  6  current minute, binary 0..59
- sec_out  output  6  current second, binary 0..59
- sec_tick  output  1  one-cycle pulse when sec_out advances
- edit_field  output  2  00 = running, 01 = editing hour, 10 = editing minute

Behaviour:
- Reset state (reset_n low, asynchronous):
  - hour_out = RESET_HOUR, min_out = RESET_MIN, sec_out = 0.
  - sec_tick = 0, edit_field = 00, prescaler = 0, FSM = RUN.
  - All synchronizer and edge flops = 0.
- Reset mid-operation: all state is discarded immediately, including mid-edit; no partial update survives.
- Input conditioning:
  - set_en, btn_sel and btn_inc each pass through a 2-flop synchronizer.
  - Buttons then go through a rising-edge detector, giving one-cycle pulses sel_p and inc_p.
  - Total latency from a button edge to its effect is 3 clk cycles.
  - Debounce is external; each rising edge of a held button counts once only.
- Prescaler:
  - Counts 0..CLK_DIV-1 in RUN only.
  - When it reaches CLK_DIV-1 it wraps to 0 and sec_tick pulses in that same cycle.
  - The time registers update on the following edge, coincident with sec_tick being observed.
- FSM states: RUN, SET_HOUR, SET_MIN.
  - RUN -> SET_HOUR when synced set_en = 1. On entry: sec_out := 0, prescaler := 0.
  - SET_HOUR <-> SET_MIN on each sel_p.
  - SET_HOUR/SET_MIN -> RUN when synced set_en = 0. Prescaler restarts from 0, so the first tick arrives CLK_DIV cycles after exit.
  - In the set states time does not advance and sec_tick stays 0.
- Increment in the set states:
  - inc_p in SET_HOUR: hour 23 -> 0, otherwise +1.
  - inc_p in SET_MIN: minute 59 -> 0, otherwise +1.
  - Editing never carries into the other field.
- Run-mode carry chain, evaluated on each tick:
  - sec 59 -> 0 and minute increments.
  - min 59 -> 0 and hour increments.
  - hour 23 -> 0.
  - Example: 23:59:59 -> 00:00:00 in a single tick.
- Simultaneous events:
  - If set_en rises in the same cycle a tick is due, the transition wins and no increment occurs.
  - If sel_p and inc_p arrive together, the increment applies to the field selected before the toggle; the toggle then takes effect.
  - inc_p and sel_p are ignored in RUN.
- edit_field is a registered decode of the FSM state.
- Outputs are always registered; there are no combinational paths from inputs.

Decomposition:
- Shared package, alarm_clock_pkg, holds:
  - state encoding constants ST_RUN/ST_SET_HOUR/ST_SET_MIN (2-bit);
  - limits HOURS_MAX = 23, MINS_MAX = 59, SECS_MAX = 59;
  - time field width TIME_W = 6 (shared with the comparator).
- Sub-module btn_sync_edge: 2-flop synchronizer plus rising-edge pulse, instantiated twice (sel, inc). set_en uses only the synchronizer half.

Test Plan:
- Reset with RESET_HOUR = 7, RESET_MIN = 30, then release with CLK_DIV = 4 -> outputs 07:30:00; sec_tick pulses every 4 cycles; sec_out = 1 after the first tick.
- Load 23:59:58 (via set mode) and run 2 ticks -> 23:59:59, then 00:00:00; sec_tick high once per step.
- set_en = 1, then 24 btn_inc edges -> hour wraps back to its start value; one btn_sel edge then 61 btn_inc edges -> minute advances by 1 mod 60; sec_out = 0 throughout; edit_field 01 then 10.
- Hold btn_inc high for 50 cycles in SET_MIN -> exactly one increment, effective 3 cycles after the edge.
- Assert set_en in the cycle the prescaler hits CLK_DIV-1 -> no sec_tick, seconds unchanged, FSM enters SET_HOUR and sec_out cleared to 0.
- Pull reset_n low between two clk edges during SET_MIN -> outputs return to reset values immediately, edit_field = 00, and no edit is retained after release.
